// File: rtl/qbert_pkg.sv
// Shared types and helpers for the Q*bert hop controller.
package qbert_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOP,
    LAND,
    DONE,
    FALL
  } hop_state_t;

  // Jump direction codes as presented on e_jump_qb
  localparam logic [2:0] DIR_UR = 3'd1;  // (r-1, c)
  localparam logic [2:0] DIR_UL = 3'd2;  // (r-1, c-1)
  localparam logic [2:0] DIR_DR = 3'd3;  // (r+1, c+1)
  localparam logic [2:0] DIR_DL = 3'd4;  // (r+1, c)

  // Linear cube number: rows are packed top-down, row r holds r+1 cubes
  function automatic int cube_index(input int row, input int col);
    return row * (row + 1) / 2 + col;
  endfunction

endpackage

// File: rtl/pyramid_neighbor.sv
// Combinational neighbour lookup: where a hop in direction dir lands
// and whether that landing spot is still on the pyramid.
module pyramid_neighbor #(
  parameter int N_ROWS = 7,
  parameter int RW     = 3
) (
  input  logic [RW-1:0] row,
  input  logic [RW-1:0] col,
  input  logic [2:0]    dir,
  output logic [RW-1:0] t_row,
  output logic [RW-1:0] t_col,
  output logic          in_range,
  output logic          dir_valid
);
  import qbert_pkg::*;

  int r, c, tr, tc;

  // Signed arithmetic so off-pyramid targets (negative row/col) are detectable
  always_comb begin
    r         = int'(row);
    c         = int'(col);
    tr        = r;
    tc        = c;
    dir_valid = 1'b1;
    case (dir)
      DIR_UR:  tr = r - 1;
      DIR_UL:  begin tr = r - 1; tc = c - 1; end
      DIR_DR:  begin tr = r + 1; tc = c + 1; end
      DIR_DL:  tr = r + 1;
      default: dir_valid = 1'b0;
    endcase
    // tc <= tr catches the up-right move off the right edge of a row
    in_range = dir_valid && (tr >= 0) && (tc >= 0) && (tc <= tr) && (tr < N_ROWS);
    t_row    = RW'(tr);
    t_col    = RW'(tc);
  end

endmodule

// File: rtl/qbert_hop_controller.sv
// Q*bert hop controller: moves Q*bert between pyramid cubes on jump
// commands, times each hop/fall in frame ticks and tracks recoloured tops.
module qbert_hop_controller #(
  parameter int N_ROWS      = 7,
  parameter int N_cube      = N_ROWS * (N_ROWS + 1) / 2,
  parameter int HOP_FRAMES  = 8,
  parameter int FALL_FRAMES = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              jump_req,
  input  logic [2:0]        e_jump_qb,
  input  logic              level_reset,
  output logic [N_cube-1:0] position_qb,
  output logic [N_cube-1:0] e_next_qb,
  output logic [N_cube-1:0] e_color_state,
  output logic              done_move,
  output logic              fall_done,
  output logic              busy,
  output logic [3:0]        hop_frame,
  output logic              level_clear
);
  import qbert_pkg::*;

  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam logic [N_cube-1:0] CUBE0     = {{(N_cube-1){1'b0}}, 1'b1};
  localparam logic [3:0]        HOP_LAST  = 4'(HOP_FRAMES - 1);
  localparam logic [3:0]        FALL_LAST = 4'(FALL_FRAMES - 1);

  hop_state_t        state;
  logic [RW-1:0]     row, col, t_row, t_col;
  logic [RW-1:0]     nb_row, nb_col;
  logic              nb_in_range, nb_dir_valid;
  logic [N_cube-1:0] tgt_oh;

  pyramid_neighbor #(.N_ROWS(N_ROWS), .RW(RW)) u_nb (
    .row       (row),
    .col       (col),
    .dir       (e_jump_qb),
    .t_row     (nb_row),
    .t_col     (nb_col),
    .in_range  (nb_in_range),
    .dir_valid (nb_dir_valid)
  );

  assign tgt_oh = CUBE0 << cube_index(int'(nb_row), int'(nb_col));

  // Hop/fall sequencer; every output is a register updated here
  always_ff @(posedge clk) begin
    if (reset || level_reset) begin
      state         <= IDLE;
      row           <= '0;
      col           <= '0;
      t_row         <= '0;
      t_col         <= '0;
      position_qb   <= CUBE0;
      e_next_qb     <= CUBE0;
      e_color_state <= '0;
      done_move     <= 1'b0;
      fall_done     <= 1'b0;
      busy          <= 1'b0;
      hop_frame     <= '0;
      level_clear   <= 1'b0;
    end else begin
      done_move   <= 1'b0;
      fall_done   <= 1'b0;
      level_clear <= &e_color_state;
      case (state)
        IDLE: begin
          // A tick coinciding with acceptance is not counted: hop_frame restarts at 0
          if (jump_req && nb_dir_valid && !level_clear) begin
            busy      <= 1'b1;
            hop_frame <= '0;
            if (nb_in_range) begin
              t_row     <= nb_row;
              t_col     <= nb_col;
              e_next_qb <= tgt_oh;
              state     <= HOP;
            end else begin
              state <= FALL;
            end
          end
        end
        HOP: begin
          if (frame_tick) begin
            if (hop_frame == HOP_LAST) begin
              // Landing takes effect on the edge into LAND so position and
              // target only differ while in HOP
              hop_frame     <= '0;
              row           <= t_row;
              col           <= t_col;
              position_qb   <= e_next_qb;
              e_color_state <= e_color_state | e_next_qb;
              state         <= LAND;
            end else begin
              hop_frame <= hop_frame + 4'd1;
            end
          end
        end
        LAND: begin
          // done_move is high during DONE, one cycle after colours settle
          done_move <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        FALL: begin
          if (frame_tick) begin
            if (hop_frame == FALL_LAST) begin
              hop_frame   <= '0;
              row         <= '0;
              col         <= '0;
              position_qb <= CUBE0;
              e_next_qb   <= CUBE0;
              fall_done   <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
            end else begin
              hop_frame <= hop_frame + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qbert_hop_controller.sv
// Scoreboard bench for qbert_hop_controller: the driver predicts each hop
// or fall from pyramid geometry and queues the expected landing; a monitor
// checks every done_move / fall_done pulse against the queue.
module tb_qbert_hop_controller;
  localparam int NR = 7;
  localparam int NC = 28;
  localparam int HF = 8;
  localparam int FF = 12;

  logic          clk = 1'b0;
  logic          reset, frame_tick, jump_req, level_reset;
  logic [2:0]    e_jump_qb;
  logic [NC-1:0] position_qb, e_next_qb, e_color_state;
  logic          done_move, fall_done, busy, level_clear;
  logic [3:0]    hop_frame;

  always #5 clk = ~clk;

  qbert_hop_controller #(.N_ROWS(NR), .HOP_FRAMES(HF), .FALL_FRAMES(FF)) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .jump_req      (jump_req),
    .e_jump_qb     (e_jump_qb),
    .level_reset   (level_reset),
    .position_qb   (position_qb),
    .e_next_qb     (e_next_qb),
    .e_color_state (e_color_state),
    .done_move     (done_move),
    .fall_done     (fall_done),
    .busy          (busy),
    .hop_frame     (hop_frame),
    .level_clear   (level_clear)
  );

  typedef struct {
    bit            is_fall;
    logic [NC-1:0] pos;
    logic [NC-1:0] col;
  } exp_t;

  exp_t          sb[$];
  int            n_chk = 0;
  int            n_err = 0;
  bit            mon_en = 1'b0;
  int            mr, mc;     // model position
  logic [NC-1:0] mcol;       // model recoloured set

  function automatic logic [NC-1:0] oh(input int r, input int c);
    logic [NC-1:0] one;
    one = 1;
    return one << (r * (r + 1) / 2 + c);
  endfunction

  // 0 = ignored, 1 = hop to (nr,nc), 2 = falls off
  function automatic int outcome(input int d, input int r, input int c,
                                 output int nr, output int nc);
    nr = r;
    nc = c;
    case (d)
      1: nr = r - 1;
      2: begin nr = r - 1; nc = c - 1; end
      3: begin nr = r + 1; nc = c + 1; end
      4: nr = r + 1;
      default: return 0;
    endcase
    if (nr < 0 || nc < 0 || nc > nr || nr >= NR) return 2;
    return 1;
  endfunction

  task automatic chk(input string name, input logic [NC-1:0] act, input logic [NC-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  // Idle cycles between ticks; mode 1 sprinkles random requests, mode 2 a DL request
  task automatic gap(input int mode);
    int n;
    n = (mode == 2) ? 1 : $urandom_range(0, 2);
    repeat (n) begin
      if (mode == 2 || (mode == 1 && $urandom_range(0, 3) == 0)) begin
        jump_req  = 1'b1;
        e_jump_qb = (mode == 2) ? 3'd4 : 3'($urandom_range(0, 7));
      end
      step();
      jump_req = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20 && busy; i++) step();
    if (busy) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_timeout: busy still 1, want 0", name);
    end
  endtask

  task automatic do_jump(input int d, input int mode);
    int nr, nc, o, pr, pc;
    o = outcome(d, mr, mc, nr, nc);
    if (&mcol) o = 0;
    pr = mr;
    pc = mc;
    jump_req   = 1'b1;
    e_jump_qb  = 3'(d);
    frame_tick = 1'($urandom_range(0, 1));
    step();
    jump_req   = 1'b0;
    frame_tick = 1'b0;
    if (o == 0) begin
      chk("ignored_busy", NC'(busy), NC'(0));
      chk("ignored_next", e_next_qb, oh(pr, pc));
      return;
    end
    chk("busy_after_accept", NC'(busy), NC'(1));
    if (o == 1) begin
      chk("next_target", e_next_qb, oh(nr, nc));
      chk("pos_during_hop", position_qb, oh(pr, pc));
      mr = nr;
      mc = nc;
      mcol |= oh(nr, nc);
      sb.push_back('{1'b0, oh(nr, nc), mcol});
      for (int k = 1; k <= HF; k++) begin
        gap(mode);
        tick();
        chk("hop_frame", NC'(hop_frame), NC'(k % HF));
      end
      chk("pos_at_land", position_qb, oh(mr, mc));
      chk("color_at_land", e_color_state, mcol);
    end else begin
      chk("fall_next_hold", e_next_qb, oh(pr, pc));
      mr = 0;
      mc = 0;
      sb.push_back('{1'b1, oh(0, 0), mcol});
      for (int k = 1; k <= FF; k++) begin
        gap(mode);
        tick();
        if (k < FF) begin
          chk("fall_frame", NC'(hop_frame), NC'(k));
          chk("fall_next_hold", e_next_qb, oh(pr, pc));
        end
      end
      chk("fall_busy_drop", NC'(busy), NC'(0));
    end
    wait_idle("hop");
    chk("level_clear", NC'(level_clear), NC'(&mcol));
  endtask

  // Monitor: every landing/respawn pulse must match the oldest prediction
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && (done_move || fall_done)) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_pulse: done_move=%0b fall_done=%0b, want no pulse", done_move, fall_done);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", NC'({fall_done, done_move}), NC'(e.is_fall ? 2'b10 : 2'b01));
        chk("pulse_pos", position_qb, e.pos);
        chk("pulse_next", e_next_qb, e.pos);
        chk("pulse_color", e_color_state, e.col);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    int cand[$];
    int un[$];
    int nr, nc;
    reset = 1'b1; level_reset = 1'b0; frame_tick = 1'b0; jump_req = 1'b0; e_jump_qb = 3'd0;
    mr = 0; mc = 0; mcol = '0;
    repeat (3) step();
    chk("rst_pos", position_qb, NC'(1));
    chk("rst_next", e_next_qb, NC'(1));
    chk("rst_color", e_color_state, NC'(0));
    chk("rst_flags", NC'({busy, done_move, fall_done, level_clear}), NC'(0));
    chk("rst_hop_frame", NC'(hop_frame), NC'(0));
    reset = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 0) frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      chk("idle_quiet", NC'({busy, done_move, fall_done}), NC'(0));
    end

    // Directed: DR from top, UL back, UL off the top, DR with a DL request mid-hop
    do_jump(3, 0);
    do_jump(2, 0);
    do_jump(2, 0);
    do_jump(3, 2);

    // Random walk with invalid codes, falls and dropped requests
    for (int i = 0; i < 60; i++) do_jump($urandom_range(0, 7), 1);

    // Level reset at hop_frame 4 of an accepted hop
    for (int d = 1; d <= 4; d++) if (outcome(d, mr, mc, nr, nc) == 1) e_jump_qb = 3'(d);
    jump_req = 1'b1;
    step();
    jump_req = 1'b0;
    chk("lr_accept", NC'(busy), NC'(1));
    repeat (4) tick();
    chk("lr_frame", NC'(hop_frame), NC'(4));
    level_reset = 1'b1;
    step();
    level_reset = 1'b0;
    mr = 0; mc = 0; mcol = '0;
    chk("lr_busy", NC'(busy), NC'(0));
    chk("lr_pos", position_qb, NC'(1));
    chk("lr_next", e_next_qb, NC'(1));
    chk("lr_color", e_color_state, NC'(0));
    chk("lr_hop_frame", NC'(hop_frame), NC'(0));
    repeat (10) tick();
    chk("lr_still_idle", NC'(busy), NC'(0));

    // Cover the whole pyramid, preferring unvisited neighbours
    for (int h = 0; h < 1500 && !(&mcol); h++) begin
      cand.delete();
      un.delete();
      for (int d = 1; d <= 4; d++) begin
        if (outcome(d, mr, mc, nr, nc) == 1) begin
          cand.push_back(d);
          if (!mcol[nr * (nr + 1) / 2 + nc]) un.push_back(d);
        end
      end
      if (un.size() > 0) do_jump(un[$urandom_range(0, un.size() - 1)], 0);
      else do_jump(cand[$urandom_range(0, cand.size() - 1)], 0);
    end
    chk("tour_complete", NC'(&mcol), NC'(1));
    chk("level_clear_set", NC'(level_clear), NC'(1));
    chk("all_colored", e_color_state, {NC{1'b1}});
    do_jump((mr < NR - 1) ? 4 : 1, 0);
    do_jump(2, 0);

    repeat (5) step();
    chk("sb_drained", NC'(sb.size()), NC'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
